// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Memory burst sizes follow the memory block's access_size encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        BURST,
        DRAIN,
        FLUSH
    } fetch_state_t;

    localparam logic [1:0] ACC_1W  = 2'd0;
    localparam logic [1:0] ACC_4W  = 2'd1;
    localparam logic [1:0] ACC_8W  = 2'd2;
    localparam logic [1:0] ACC_16W = 2'd3;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 16;

    function automatic logic [31:0] line_addr(
        input logic [31:2] pc
    );
        return {pc[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Burst read bus between fetch (master) and memory (slave).
// Signal names mirror the memory block's ports.
interface fetch_if;

    logic [31:0] mem_addr;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr;
    logic        mem_enable;
    logic [31:0] mem_data;
    logic        mem_busy;

    modport master (
        output mem_addr,
        output mem_access_size,
        output mem_rd_wr,
        output mem_enable,
        input  mem_data,
        input  mem_busy
    );

    modport slave (
        input  mem_addr,
        input  mem_access_size,
        input  mem_rd_wr,
        input  mem_enable,
        output mem_data,
        output mem_busy
    );

endinterface

// File: rtl/fetch_line_buffer.sv
// One cache-line of fetched words with per-entry valid bits.
// Clear-all wins over any write or single-entry clear.
module fetch_line_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  widx,
    input  logic [31:0] wdata,
    input  logic        clr_all,
    input  logic        clr_one,
    input  logic [1:0]  cidx,
    input  logic [1:0]  ridx,
    output logic [31:0] rdata,
    output logic        rvalid
);

    logic [31:0]           data_q [LINE_WORDS];
    logic [LINE_WORDS-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[widx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else begin
            if (we) begin
                valid_q[widx] <= 1'b1;
            end
            if (clr_one) begin
                valid_q[cidx] <= 1'b0;
            end
        end
    end

    assign rdata  = data_q[ridx];
    assign rvalid = valid_q[ridx];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: 4-word burst reads into a line buffer, one
// instruction per handshake to decode, flushed on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h80020000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     mem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    fetch_state_t state_q, state_d;
    logic [31:2]  pc_q, pc_d;
    logic [1:0]   beat_q, beat_d;
    logic [2:0]   flush_q, flush_d;
    logic [1:0]   head_q, head_d;

    logic        req_en;
    logic        accept;
    logic        fire;
    logic        buf_we;
    logic        buf_clr_all;
    logic        buf_clr_one;
    logic [31:0] buf_rdata;
    logic        buf_rvalid;
    logic        unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];

    // Memory outputs depend only on registered state (and reset).
    assign req_en              = (state_q == REQ) & ~reset;
    assign mem.mem_enable      = req_en;
    assign mem.mem_addr        = line_addr(pc_q);
    assign mem.mem_access_size = ACC_4W;
    assign mem.mem_rd_wr       = 1'b1;

    assign accept = req_en & ~mem.mem_busy;

    assign inst_valid = buf_rvalid &
                        ((state_q == BURST) |
                         (state_q == DRAIN));
    assign inst    = inst_valid ? buf_rdata : '0;
    assign inst_pc = {pc_q[31:4], head_q, 2'b00};
    assign fire    = inst_valid & inst_ready;

    fetch_line_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (buf_we),
        .widx    (beat_q),
        .wdata   (mem.mem_data),
        .clr_all (buf_clr_all),
        .clr_one (buf_clr_one),
        .cidx    (head_q),
        .ridx    (head_q),
        .rdata   (buf_rdata),
        .rvalid  (buf_rvalid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC[31:2];
            beat_q  <= 2'd0;
            flush_q <= 3'd0;
            head_q  <= RESET_PC[3:2];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            head_q  <= head_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        beat_d      = beat_q;
        flush_d     = flush_q;
        head_d      = head_q;
        buf_we      = 1'b0;
        buf_clr_all = 1'b0;
        buf_clr_one = fire;

        if (fire) begin
            head_d = head_q + 2'd1;
        end

        unique case (state_q)
            REQ: begin
                if (accept) begin
                    state_d     = BURST;
                    beat_d      = 2'd0;
                    head_d      = pc_q[3:2];
                    buf_clr_all = 1'b1;
                end
            end
            BURST: begin
                buf_we = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fire && head_q == 2'd3) begin
                    state_d = REQ;
                    pc_d    = {pc_q[31:4] + 28'd1, 2'b00};
                end
            end
            FLUSH: begin
                if (flush_q <= 3'd1) begin
                    state_d = REQ;
                end else begin
                    flush_d = flush_q - 3'd1;
                end
            end
        endcase

        // Beats still owed by memory must be swallowed before
        // the next request can be issued.
        if (redirect) begin
            pc_d = redirect_pc[31:2];
            if (state_q != FLUSH) begin
                buf_clr_all = 1'b1;
                buf_we      = 1'b0;
                if (state_q == BURST) begin
                    state_d = FLUSH;
                    flush_d = 3'd3 - {1'b0, beat_q};
                end else if (accept) begin
                    state_d = FLUSH;
                    flush_d = 3'd4;
                end else begin
                    state_d = REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: burst memory model plus an in-order
// instruction stream model checked at every handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_if mif ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mif),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          n_hs = 0;
    logic [31:0] exp_pc = 32'h80020000;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h80020000 && a <= 32'h8002001C)
            return 32'h11111111 * (((a - 32'h80020000) >> 2) + 1);
        return a ^ 32'hC3C30000;
    endfunction

    // memory: accept when enable & !busy, 4 beats after accept
    int          mcnt = 0;
    logic [31:0] maddr = '0;
    logic        acc_s;
    logic [31:0] addr_s;
    logic        force_busy = 1'b0;
    logic [31:0] req_q [$];

    assign mif.mem_busy = force_busy | (mcnt >= 1 && mcnt <= 3);
    assign mif.mem_data = (mcnt != 0) ?
        mem_word(maddr + 32'(4 * (mcnt - 1))) : 32'hDEADBEEF;

    always begin
        @(negedge clk);
        #2;
        acc_s  = mif.mem_enable && !mif.mem_busy;
        addr_s = mif.mem_addr;
        if (acc_s) req_q.push_back(addr_s);
        @(posedge clk);
        #1;
        if (acc_s) begin
            mcnt  = 1;
            maddr = addr_s;
        end else if (mcnt != 0) begin
            mcnt = (mcnt == 4) ? 0 : mcnt + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check any handshake, advance.
    task automatic cycle(input logic rdy, input logic rd,
                         input logic [31:0] rpc);
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (inst_valid && inst_ready) begin
            chk("stream_pc", inst_pc, exp_pc);
            chk("stream_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_hs++;
        end
        if (rd) exp_pc = rpc & ~32'h3;
        @(negedge clk);
    endtask

    task automatic run_hs(input int cnt, input int budget);
        int target;
        int k;
        target = n_hs + cnt;
        k = 0;
        while (n_hs < target && k < budget) begin
            cycle(1'b1, 1'b0, 32'h0);
            k++;
        end
        chk("hs_progress", 32'(n_hs), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        exp_pc = 32'h80020000;
        req_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        @(negedge clk);
        repeat (2) cycle(1'b0, 1'b0, 32'h0);

        chk("rst_enable", 32'(mif.mem_enable), 32'd0);
        chk("rst_addr", mif.mem_addr, 32'h80020000);
        chk("rst_size", 32'(mif.mem_access_size), 32'(ACC_4W));
        chk("rst_rdwr", 32'(mif.mem_rd_wr), 32'd1);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h80020000);

        // run straight through two lines
        exp_pc = 32'h80020000;
        reset = 1'b0;
        #1;
        chk("c0_enable", 32'(mif.mem_enable), 32'd1);
        chk("c0_valid", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c1_valid", 32'(inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c2_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst", inst, 32'h11111111);
        run_hs(8, 60);
        chk("req_count", 32'(req_q.size() >= 2), 32'd1);
        chk("req0", req_q[0], 32'h80020000);
        chk("req1", req_q[1], 32'h80020010);

        // backpressure on word 1
        do_reset();
        reset = 1'b0;
        run_hs(1, 20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, 32'h22222222);
            chk("bp_pc", inst_pc, 32'h80020004);
            cycle(1'b0, 1'b0, 32'h0);
        end
        run_hs(7, 60);

        // redirect while draining
        do_reset();
        reset = 1'b0;
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        chk("drain_hold", inst, 32'h11111111);
        req_q.delete();
        cycle(1'b0, 1'b1, 32'h80020018);
        run_hs(2, 40);
        chk("drain_req", req_q[0], 32'h80020010);

        // redirect during beat 1
        do_reset();
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        req_q.delete();
        cycle(1'b0, 1'b1, 32'h80020004);
        for (int i = 0; i < 2; i++) begin
            chk("flush_en", 32'(mif.mem_enable), 32'd0);
            chk("flush_valid", 32'(inst_valid), 32'd0);
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("flush_req_en", 32'(mif.mem_enable), 32'd1);
        chk("flush_req_addr", mif.mem_addr, 32'h80020000);
        chk("flush_no_req", 32'(req_q.size()), 32'd0);
        run_hs(3, 40);
        chk("flush_req", req_q[0], 32'h80020000);

        // memory busy at request
        do_reset();
        force_busy = 1'b1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("busy_en", 32'(mif.mem_enable), 32'd1);
            chk("busy_addr", mif.mem_addr, 32'h80020000);
            chk("busy_noacc", 32'(req_q.size()), 32'd0);
            cycle(1'b1, 1'b0, 32'h0);
        end
        force_busy = 1'b0;
        cycle(1'b1, 1'b0, 32'h0);
        chk("busy_acc", 32'(req_q.size()), 32'd1);
        run_hs(4, 40);

        // address wrap at top of memory
        cycle(1'b1, 1'b1, 32'hFFFFFFF2);
        run_hs(6, 80);
        chk("wrap_req_a", req_q[req_q.size() - 2], 32'hFFFFFFF0);
        chk("wrap_req_b", req_q[req_q.size() - 1], 32'h00000000);

        // random backpressure and redirects
        do_reset();
        reset = 1'b0;
        base = n_hs;
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] rpc;
            rdy = ($urandom_range(3) != 0);
            rd  = ($urandom_range(24) == 0);
            rpc = $urandom_range(1) != 0 ?
                  (32'h80020000 | ($urandom & 32'h3F)) : $urandom;
            cycle(rdy, rd, rpc);
        end
        chk("rand_progress", 32'((n_hs - base) >= 40), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
